uart_baud_gen: RTL
==================

// Module: uart_baud_gen
// PURPOSE
//   Programmable UART baud tick generator; successor to the fixed 2604-cycle TX enable.
//   - Runtime-loadable divisor produces an oversample tick (tick_os) for the RX sampler.
//   - A derived bit tick (tick_tx) fires once per OVERSAMPLE oversample ticks for the TX shifter.
//   - Sits between the system clock domain and the UART TX/RX datapaths.
//   - RX resynchronises the phase on start-bit detection through resync.
// PARAMETERS
//   DIV_W        16   width of integer divisor
//   OVERSAMPLE   16   tick_os per tick_tx (>=2)
//   DEFAULT_DIV  163  divisor after reset (50 MHz / (19200*16) ~ 162.76)
//   FRAC_W       4    fractional divisor bits (used only with UART_BAUD_FRAC_EN)
// PORTS
//   clk          in   1       system clock (50 MHz nominal)
//   reset        in   1       synchronous, active-high reset
//   baud_en      in   1       1 = generate ticks, 0 = hold counters at 0
//   div_i        in   DIV_W   new integer divisor (clk cycles per tick_os)
//   div_frac_i   in   FRAC_W  new fractional divisor, in 1/2^FRAC_W cycle units
//   div_load     in   1       1-cycle strobe: capture div_i/div_frac_i into the pending register
//   resync       in   1       1-cycle strobe: restart the phase of both counters
//   tick_os      out  1       1-cycle pulse every div cycles
//   tick_tx      out  1       1-cycle pulse coincident with every OVERSAMPLE-th tick_os
//   div_pending  out  1       high from the load strobe until the new divisor is in use
// BEHAVIOUR
//   Reset (all sync, active-high):
//     - div_act = pend = DEFAULT_DIV; frac_act = frac_acc = 0.
//     - os_cnt = tx_cnt = 0; tick_os = tick_tx = div_pending = 0.
//   Divisor clamp: a loaded div_i < 2 is stored as 2. Minimum tick_os period is 2 cycles.
//   Oversample counter:
//     - os_cnt counts 0..div_act-1 while baud_en = 1.
//     - On the cycle os_cnt == div_act-1 (wrap), tick_os is registered high for the next cycle.
//     - os_cnt then returns to 0, so the tick_os period is exactly div_act cycles.
//   Bit counter:
//     - tx_cnt increments on each wrap and counts 0..OVERSAMPLE-1.
//     - tick_tx is asserted in the same cycle as the tick_os on which tx_cnt wraps.
//     - tick_tx period = div_act*OVERSAMPLE cycles.
//   Outputs are registered: 1-cycle latency from wrap detect to tick.
//   baud_en:
//     - baud_en = 0: os_cnt and tx_cnt are forced to 0 and both ticks are 0 from the next cycle.
//     - The first tick_os comes div_act cycles after baud_en rises.
//     - The first tick_tx comes div_act*OVERSAMPLE cycles after baud_en rises.
//   div_load:
//     - Captures into pend and sets div_pending.
//     - pend is copied to div_act on the next wrap, or immediately if baud_en = 0.
//     - div_pending clears in the same cycle as that copy.
//     - A second load before the copy overwrites pend (last write wins).
//     - The running period is never truncated.
//   resync:
//     - os_cnt = tx_cnt = 0 and no tick is produced that cycle, even if a wrap coincides.
//     - Applies pend if div_pending = 1.
//     - resync together with div_load: the new value loads and is applied at once.
//   Priority: reset > resync > baud_en = 0 > wrap/load.
// CONFIGURATION
//   UART_BAUD_FRAC_EN defined:
//     - On every wrap, frac_acc += frac_act (FRAC_W-bit accumulator).
//     - A carry-out lengthens the following tick_os period to div_act+1 cycles.
//     - Long-run tick_os period = div_act + frac_act/2^FRAC_W cycles.
//     - frac_act is loaded together with div_act; frac_acc clears on reset, resync and baud_en = 0.
//   UART_BAUD_FRAC_EN undefined:
//     - div_frac_i is ignored and no accumulator logic is built.
//     - The period is always div_act.
// TESTING
//   1. Reset, then baud_en = 1 with defaults -> first tick_os at cycle 163, then every 163; tick_tx every 2608.
//   2. Running, baud_en = 0 for 500 cycles, then 1 -> no ticks while low; next tick_os 163 cycles after the rise.
//   3. div_load with div_i = 50 at mid-period -> current period stays 163; then 50-cycle periods.
//      div_pending is high only until the applying wrap.
//   4. div_load with div_i = 0 -> period 2 (clamp); tick_tx every 32 cycles.
//   5. resync 40 cycles after a tick_os, and resync on a wrap cycle -> next tick_os 163 cycles after the resync.
//      The coincident tick is suppressed; tx_cnt restarts.
//   6. [UART_BAUD_FRAC_EN] div_i = 162, div_frac_i = 12 -> 16 consecutive tick_os periods total exactly 2604 cycles.
//      Twelve periods are 163 cycles and four are 162.

Source files
------------

// File: rtl/uart_baud_gen_if.sv
// -----------------------------------------------------------------------------
// uart_baud_gen_if
//   Control/status bundle between a UART controller and the baud tick
//   generator.
//
//   master modport (controller side):
//     baud_en     out  enable tick generation
//     div_i       out  new integer divisor (clk cycles per tick_os)
//     div_frac_i  out  new fractional divisor, 1/2^FRAC_W cycle units
//     div_load    out  1-cycle strobe, captures div_i/div_frac_i
//     resync      out  1-cycle strobe, restarts the tick phase
//     tick_os     in   oversample tick
//     tick_tx     in   bit tick (every OVERSAMPLE-th tick_os)
//     div_pending in   a loaded divisor is waiting to take effect
//   slave modport: the generator side, directions mirrored.
// -----------------------------------------------------------------------------
interface uart_baud_gen_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
) ();
    logic              baud_en;
    logic [DIV_W-1:0]  div_i;
    logic [FRAC_W-1:0] div_frac_i;
    logic              div_load;
    logic              resync;
    logic              tick_os;
    logic              tick_tx;
    logic              div_pending;

    modport master (
        output baud_en, div_i, div_frac_i, div_load, resync,
        input  tick_os, tick_tx, div_pending
    );

    modport slave (
        input  baud_en, div_i, div_frac_i, div_load, resync,
        output tick_os, tick_tx, div_pending
    );
endinterface

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//   Programmable UART baud tick generator. A runtime-loadable divisor produces
//   an oversample tick (tick_os) every div_act clk cycles for the RX sampler;
//   every OVERSAMPLE-th tick_os is also flagged as a bit tick (tick_tx) for the
//   TX shifter. resync restarts the phase (RX start-bit alignment).
//
//   Ports:
//     clk     in  system clock
//     reset   in  synchronous, active-high reset
//     bus     uart_baud_gen_if.slave:
//               baud_en, div_i, div_frac_i, div_load, resync  (inputs)
//               tick_os, tick_tx, div_pending                 (outputs)
//
//   Configuration:
//     UART_BAUD_FRAC_EN  when defined, a FRAC_W-bit fractional accumulator
//                        stretches some periods by one cycle so the long-run
//                        period is div_act + frac_act/2^FRAC_W. When not
//                        defined, div_frac_i is ignored and the period is
//                        always div_act.
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int DIV_W       = 16,
    parameter int OVERSAMPLE  = 16,
    parameter int DEFAULT_DIV = 163,
    parameter int FRAC_W      = 4
) (
    input  logic           clk,
    input  logic           reset,
    uart_baud_gen_if.slave bus
);
    localparam int TX_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
    localparam logic [TX_W-1:0]  TX_LAST = TX_W'(OVERSAMPLE - 1);

    logic [DIV_W-1:0] div_act_reg;
    logic [DIV_W-1:0] pend_reg;
    logic [DIV_W-1:0] os_cnt_reg;
    logic [TX_W-1:0]  tx_cnt_reg;
    logic             tick_os_reg;
    logic             tick_tx_reg;
    logic             div_pending_reg;

    logic [DIV_W-1:0] load_div;
    logic [DIV_W-1:0] div_next;
    logic [DIV_W-1:0] period_last;
    logic             pending_any;
    logic             apply_pend;
    logic             wrap;
    logic             tx_wrap;

    // Divisors below 2 would give a tick every cycle (or never); clamp.
    assign load_div = (bus.div_i < DIV_MIN) ? DIV_MIN : bus.div_i;

    // A load in the same cycle as an apply opportunity takes effect at once,
    // so the freshly captured value bypasses pend_reg.
    assign div_next    = bus.div_load ? load_div : pend_reg;
    assign pending_any = bus.div_load | div_pending_reg;

    assign wrap       = bus.baud_en & (os_cnt_reg == period_last);
    assign tx_wrap    = (tx_cnt_reg == TX_LAST);

    // The pending divisor only swaps in at a period boundary, on resync or
    // while idle, so a running period is never cut short.
    assign apply_pend = pending_any & (bus.resync | ~bus.baud_en | wrap);

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] frac_act_reg;
    logic [FRAC_W-1:0] pend_frac_reg;
    logic [FRAC_W-1:0] frac_acc_reg;
    logic [FRAC_W-1:0] frac_next;
    logic [FRAC_W:0]   acc_sum;
    logic              extend_reg;

    assign frac_next   = bus.div_load ? bus.div_frac_i : pend_frac_reg;
    assign acc_sum     = {1'b0, frac_acc_reg} + {1'b0, frac_act_reg};
    // A carry out of the accumulator stretches the following period by one.
    assign period_last = div_act_reg - DIV_W'(1) + DIV_W'(extend_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            frac_act_reg  <= '0;
            pend_frac_reg <= '0;
            frac_acc_reg  <= '0;
            extend_reg    <= 1'b0;
        end else begin
            if (bus.div_load) begin
                pend_frac_reg <= bus.div_frac_i;
            end
            if (apply_pend) begin
                frac_act_reg <= frac_next;
            end
            if (bus.resync || !bus.baud_en) begin
                frac_acc_reg <= '0;
                extend_reg   <= 1'b0;
            end else if (wrap) begin
                // Accumulate with the fraction of the period just finished.
                frac_acc_reg <= acc_sum[FRAC_W-1:0];
                extend_reg   <= acc_sum[FRAC_W];
            end
        end
    end
`else
    logic unused_frac;
    assign unused_frac = ^bus.div_frac_i;
    assign period_last = div_act_reg - DIV_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            div_act_reg     <= DIV_RST;
            pend_reg        <= DIV_RST;
            div_pending_reg <= 1'b0;
            os_cnt_reg      <= '0;
            tx_cnt_reg      <= '0;
            tick_os_reg     <= 1'b0;
            tick_tx_reg     <= 1'b0;
        end else begin
            if (bus.div_load) begin
                pend_reg <= load_div;
            end
            if (apply_pend) begin
                div_act_reg     <= div_next;
                div_pending_reg <= 1'b0;
            end else if (bus.div_load) begin
                div_pending_reg <= 1'b1;
            end

            if (bus.resync) begin
                // The resync cycle itself is count 0 of the new period, which
                // puts the next tick_os exactly div_act cycles later, the same
                // spacing as after a baud_en rise.
                os_cnt_reg  <= bus.baud_en ? DIV_W'(1) : '0;
                tx_cnt_reg  <= '0;
                tick_os_reg <= 1'b0;
                tick_tx_reg <= 1'b0;
            end else if (!bus.baud_en) begin
                os_cnt_reg  <= '0;
                tx_cnt_reg  <= '0;
                tick_os_reg <= 1'b0;
                tick_tx_reg <= 1'b0;
            end else if (wrap) begin
                os_cnt_reg  <= '0;
                tx_cnt_reg  <= tx_wrap ? '0 : tx_cnt_reg + TX_W'(1);
                tick_os_reg <= 1'b1;
                tick_tx_reg <= tx_wrap;
            end else begin
                os_cnt_reg  <= os_cnt_reg + DIV_W'(1);
                tick_os_reg <= 1'b0;
                tick_tx_reg <= 1'b0;
            end
        end
    end

    assign bus.tick_os     = tick_os_reg;
    assign bus.tick_tx     = tick_tx_reg;
    assign bus.div_pending = div_pending_reg;

endmodule
